// File: rtl/sdram_bridge_pkg.sv
// Shared types for the SDRAM Avalon-MM bridge: FSM states, error bits,
// posted-write entry layout and byte-address helper.
package sdram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_WAIT
    } state_t;

    localparam logic [3:0] BYTE_EN_ALL = 4'hF;
    localparam int ERR_WR_OVF  = 0;
    localparam int ERR_RD_PEND = 1;
    localparam int WORD_W      = 26;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [31:0]       data;
    } wr_entry_t;

    // Byte address of a zero-extended word; wraps mod 2^32.
    function automatic logic [31:0] word_to_byte(
        input logic [31:0] base,
        input logic [31:0] word
    );
        return base + (word << 2);
    endfunction

endpackage

// File: rtl/sdram_wr_fifo.sv
// Posted-write FIFO for the SDRAM bridge. A push while full is only
// taken when a pop frees the head slot in the same cycle.
module sdram_wr_fifo
    import sdram_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  wr_entry_t                din,
    output wr_entry_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    wr_entry_t       mem [DEPTH];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok)  rp <= rp + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_avalon_bridge.sv
// Custom-logic word requests to Avalon-MM master with posted writes.
// Optional SDRAM_PERF_CNT_EN adds saturating read/write/stall counters.
module sdram_avalon_bridge
    import sdram_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          WR_FIFO_DEPTH = 4,
    parameter int          ADDR_W        = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdram_read_en,
    input  logic              sdram_write_en,
    input  logic [ADDR_W-1:0] address_sdram,
    input  logic [31:0]       writeData_sdram,
    output logic [31:0]       data_sdram,
    output logic              sdram_datareadvalid,
    output logic              busy,
    output logic [1:0]        err_flags,
    output logic [31:0]       avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
`ifdef SDRAM_PERF_CNT_EN
    ,
    output logic [31:0]       perf_rd_cnt,
    output logic [31:0]       perf_wr_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);
    localparam int CW = $clog2(WR_FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_nx;
    logic              pending_rd;
    logic [ADDR_W-1:0] rd_addr;
    wr_entry_t         wr_in;
    wr_entry_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              pop;
    logic              wr_accept;
    logic              rd_accept;
    logic              rd_done;

    assign pop       = (state == WR_REQ) && !avm_waitrequest;
    assign wr_accept = sdram_write_en && (!fifo_full || pop);
    assign rd_accept = sdram_read_en && !pending_rd;
    assign rd_done   = (state == RD_WAIT) && avm_readdatavalid;
    assign wr_in     = '{addr: address_sdram, data: writeData_sdram};

    assign avm_byteenable = BYTE_EN_ALL;
    assign busy           = pending_rd || (fifo_count != '0);

    sdram_wr_fifo #(.DEPTH(WR_FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sdram_write_en),
        .pop   (pop),
        .din   (wr_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A pending read only goes once every older write has drained.
    always_comb begin
        state_nx      = state;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;
        unique case (state)
            IDLE: begin
                if (pending_rd && fifo_empty)     state_nx = RD_REQ;
                else if (!fifo_empty || wr_accept) state_nx = WR_REQ;
                else if (rd_accept)               state_nx = RD_REQ;
            end
            WR_REQ: begin
                avm_write     = 1'b1;
                avm_address   = word_to_byte(BASE_ADDR, 32'(head.addr));
                avm_writedata = head.data;
                if (!avm_waitrequest) state_nx = IDLE;
            end
            RD_REQ: begin
                avm_read    = 1'b1;
                avm_address = word_to_byte(BASE_ADDR, 32'(rd_addr));
                if (!avm_waitrequest) state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                if (avm_readdatavalid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            pending_rd          <= 1'b0;
            rd_addr             <= '0;
            data_sdram          <= '0;
            sdram_datareadvalid <= 1'b0;
            err_flags           <= '0;
        end else begin
            state               <= state_nx;
            sdram_datareadvalid <= rd_done;
            if (rd_accept) begin
                pending_rd <= 1'b1;
                rd_addr    <= address_sdram;
            end else if (rd_done) begin
                pending_rd <= 1'b0;
            end
            if (rd_done) data_sdram <= avm_readdata;
            if (sdram_write_en && !wr_accept) err_flags[ERR_WR_OVF]  <= 1'b1;
            if (sdram_read_en && pending_rd)  err_flags[ERR_RD_PEND] <= 1'b1;
        end
    end

`ifdef SDRAM_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rd_cnt    <= '0;
            perf_wr_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (avm_read && !avm_waitrequest && perf_rd_cnt != '1)
                perf_rd_cnt <= perf_rd_cnt + 1'b1;
            if (avm_write && !avm_waitrequest && perf_wr_cnt != '1)
                perf_wr_cnt <= perf_wr_cnt + 1'b1;
            if ((avm_read || avm_write) && avm_waitrequest && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_avalon_bridge.sv
// Directed self-checking bench for sdram_avalon_bridge (BASE_ADDR offset
// chosen so the largest word address wraps past 2^32).
module tb_sdram_avalon_bridge;
    localparam logic [31:0] BASE = 32'hF000_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_en, write_en;
    logic [25:0] addr;
    logic [31:0] wdata;
    logic [31:0] data_sdram;
    logic        dv, busy;
    logic [1:0]  err;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
    logic [3:0]  avm_byteenable;

    int vecs = 0;
    int errs = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [1:0]  seq_q[$];
    int          rd_n = 0;
    int          dv_n = 0;

    sdram_avalon_bridge #(
        .BASE_ADDR(BASE), .WR_FIFO_DEPTH(4), .ADDR_W(26)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .sdram_read_en       (read_en),
        .sdram_write_en      (write_en),
        .address_sdram       (addr),
        .writeData_sdram     (wdata),
        .data_sdram          (data_sdram),
        .sdram_datareadvalid (dv),
        .busy                (busy),
        .err_flags           (err),
        .avm_address         (avm_address),
        .avm_read            (avm_read),
        .avm_write           (avm_write),
        .avm_writedata       (avm_writedata),
        .avm_byteenable      (avm_byteenable),
        .avm_waitrequest     (avm_waitrequest),
        .avm_readdata        (avm_readdata),
        .avm_readdatavalid   (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    // Slave-side log: 1 = write accepted, 2 = read accepted.
    always @(posedge clk) begin
        if (avm_write && !avm_waitrequest) begin
            wa_q.push_back(avm_address);
            wd_q.push_back(avm_writedata);
            seq_q.push_back(2'd1);
        end
        if (avm_read && !avm_waitrequest) begin
            rd_n++;
            seq_q.push_back(2'd2);
        end
        if (dv) dv_n++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        seq_q.delete();
        rd_n = 0;
        dv_n = 0;
    endtask

    task automatic do_reset();
        read_en = 0; write_en = 0; addr = '0; wdata = '0;
        avm_waitrequest = 0; avm_readdata = '0; avm_readdatavalid = 0;
        rst = 1;
        tick(2);
        rst = 0;
        clear_log();
    endtask

    task automatic wait_read(output bit ok);
        for (int i = 0; i < 20 && !avm_read; i++) tick();
        ok = avm_read;
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 30 && wa_q.size() < n; i++) tick();
    endtask

    // Caller is in a cycle with avm_read high and waitrequest low.
    task automatic finish_read(input logic [31:0] d);
        tick();
        avm_readdata = d;
        avm_readdatavalid = 1;
        tick();
        avm_readdatavalid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if ({avm_read, avm_write} !== 2'b00) begin errs++; $display("FAIL rst_cmd: got %b want 00", {avm_read, avm_write}); end
        vecs++; if (avm_address !== 32'h0) begin errs++; $display("FAIL rst_addr: got %h want 0", avm_address); end
        vecs++; if (avm_byteenable !== 4'hF) begin errs++; $display("FAIL rst_be: got %h want f", avm_byteenable); end
        vecs++; if ({dv, busy, err} !== 4'b0) begin errs++; $display("FAIL rst_status: got %b want 0000", {dv, busy, err}); end
        vecs++; if (data_sdram !== 32'h0) begin errs++; $display("FAIL rst_data: got %h want 0", data_sdram); end
    endtask

    task automatic test_single_read();
        do_reset();
        read_en = 1; addr = 26'd5;
        tick();
        read_en = 0;
        vecs++; if (avm_read !== 1'b1) begin errs++; $display("FAIL rd_latency: got %b want 1", avm_read); end
        vecs++; if (avm_address !== 32'hF000_0024) begin errs++; $display("FAIL rd_addr: got %h want f0000024", avm_address); end
        tick();
        vecs++; if ({avm_read, busy} !== 2'b01) begin errs++; $display("FAIL rd_wait: got %b want 01", {avm_read, busy}); end
        tick();
        avm_readdata = 32'hAABB_CCDD; avm_readdatavalid = 1;
        tick();
        avm_readdatavalid = 0; avm_readdata = '0;
        vecs++; if (dv !== 1'b1) begin errs++; $display("FAIL rd_pulse: got %b want 1", dv); end
        vecs++; if (data_sdram !== 32'hAABB_CCDD) begin errs++; $display("FAIL rd_data: got %h want aabbccdd", data_sdram); end
        tick();
        vecs++; if ({dv, busy} !== 2'b00) begin errs++; $display("FAIL rd_pulse_end: got %b want 00", {dv, busy}); end
        vecs++; if (data_sdram !== 32'hAABB_CCDD) begin errs++; $display("FAIL rd_hold: got %h want aabbccdd", data_sdram); end
        vecs++; if (dv_n !== 1) begin errs++; $display("FAIL rd_pulse_cnt: got %0d want 1", dv_n); end
    endtask

    task automatic test_addr_wrap();
        bit ok;
        do_reset();
        read_en = 1; addr = 26'h3FF_FFFF;
        tick();
        read_en = 0;
        wait_read(ok);
        vecs++; if (!ok) begin errs++; $display("FAIL wrap_timeout: got no read want read"); end
        vecs++; if (avm_address !== 32'h0000_000C) begin errs++; $display("FAIL wrap_addr: got %h want 0000000c", avm_address); end
        finish_read(32'h1234_5678);
        vecs++; if (data_sdram !== 32'h1234_5678) begin errs++; $display("FAIL wrap_data: got %h want 12345678", data_sdram); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        avm_waitrequest = 1;
        for (int i = 0; i < 4; i++) begin
            write_en = 1; addr = 26'(i); wdata = 32'hD000_0000 + i;
            tick();
        end
        write_en = 0;
        tick();
        vecs++; if ({avm_write, avm_address} !== {1'b1, BASE}) begin errs++; $display("FAIL b2b_hold: got %b %h want 1 %h", avm_write, avm_address, BASE); end
        avm_waitrequest = 0;
        wait_writes(4);
        tick(2);
        vecs++; if (wa_q.size() !== 4) begin errs++; $display("FAIL b2b_count: got %0d want 4", wa_q.size()); end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            vecs++; if (wa_q[i] !== BASE + 32'(4 * i) || wd_q[i] !== 32'hD000_0000 + i) begin errs++; $display("FAIL b2b_entry%0d: got %h/%h want %h/%h", i, wa_q[i], wd_q[i], BASE + 32'(4 * i), 32'hD000_0000 + i); end
        end
        vecs++; if ({err, busy} !== 3'b000) begin errs++; $display("FAIL b2b_status: got %b want 000", {err, busy}); end
    endtask

    task automatic test_overflow();
        do_reset();
        avm_waitrequest = 1;
        for (int i = 0; i < 5; i++) begin
            write_en = 1; addr = 26'(20 + i); wdata = 32'(i);
            tick();
        end
        write_en = 0;
        vecs++; if (err !== 2'b01) begin errs++; $display("FAIL ovf_flag: got %b want 01", err); end
        avm_waitrequest = 0;
        wait_writes(4);
        tick(3);
        vecs++; if (wa_q.size() !== 4) begin errs++; $display("FAIL ovf_count: got %0d want 4", wa_q.size()); end
        vecs++; if (wa_q.size() == 4 && wa_q[3] !== BASE + 32'd92) begin errs++; $display("FAIL ovf_last: got %h want %h", wa_q[3], BASE + 32'd92); end
        vecs++; if (err !== 2'b01) begin errs++; $display("FAIL ovf_sticky: got %b want 01", err); end
    endtask

    task automatic test_full_pop();
        do_reset();
        avm_waitrequest = 1;
        for (int i = 0; i < 4; i++) begin
            write_en = 1; addr = 26'(40 + i); wdata = 32'(i);
            tick();
        end
        addr = 26'd44; wdata = 32'h44;
        avm_waitrequest = 0;
        tick();
        write_en = 0;
        wait_writes(5);
        vecs++; if (wa_q.size() !== 5) begin errs++; $display("FAIL fullpop_count: got %0d want 5", wa_q.size()); end
        vecs++; if (wa_q.size() == 5 && wa_q[4] !== BASE + 32'd176) begin errs++; $display("FAIL fullpop_last: got %h want %h", wa_q[4], BASE + 32'd176); end
        vecs++; if (err !== 2'b00) begin errs++; $display("FAIL fullpop_err: got %b want 00", err); end
    endtask

    task automatic test_raw(input bit same_cycle);
        bit ok;
        do_reset();
        write_en = 1; addr = 26'd10; wdata = 32'h55;
        read_en = same_cycle;
        tick();
        write_en = 0;
        read_en = !same_cycle;
        if (!same_cycle) tick();
        read_en = 0;
        wait_read(ok);
        vecs++; if (!ok) begin errs++; $display("FAIL raw%0d_timeout: got no read want read", same_cycle); end
        vecs++; if (avm_address !== BASE + 32'd40) begin errs++; $display("FAIL raw%0d_addr: got %h want %h", same_cycle, avm_address, BASE + 32'd40); end
        finish_read(32'h55);
        vecs++; if (seq_q.size() < 2 || seq_q[0] !== 2'd1 || seq_q[1] !== 2'd2) begin errs++; $display("FAIL raw%0d_order: got %0d events first %0d want write then read", same_cycle, seq_q.size(), seq_q.size() > 0 ? seq_q[0] : 2'd0); end
        vecs++; if ({dv, data_sdram} !== {1'b1, 32'h55}) begin errs++; $display("FAIL raw%0d_data: got %b %h want 1 00000055", same_cycle, dv, data_sdram); end
    endtask

    task automatic test_read_pending();
        do_reset();
        read_en = 1; addr = 26'd3;
        tick();
        read_en = 0;
        tick();
        read_en = 1; addr = 26'd9;
        tick();
        read_en = 0;
        vecs++; if (err !== 2'b10) begin errs++; $display("FAIL pend_flag: got %b want 10", err); end
        tick(3);
        vecs++; if (avm_read !== 1'b0) begin errs++; $display("FAIL pend_noread: got %b want 0", avm_read); end
        avm_readdata = 32'h0BAD_F00D; avm_readdatavalid = 1;
        tick();
        avm_readdatavalid = 0;
        vecs++; if ({dv, data_sdram} !== {1'b1, 32'h0BAD_F00D}) begin errs++; $display("FAIL pend_data: got %b %h want 1 0badf00d", dv, data_sdram); end
        tick(4);
        vecs++; if (rd_n !== 1) begin errs++; $display("FAIL pend_rdcnt: got %0d want 1", rd_n); end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        read_en = 1; addr = 26'd2;
        tick();
        read_en = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        avm_readdata = 32'hDEAD_BEEF; avm_readdatavalid = 1;
        tick();
        avm_readdatavalid = 0;
        vecs++; if ({dv, busy, avm_read} !== 3'b000) begin errs++; $display("FAIL midrst_status: got %b want 000", {dv, busy, avm_read}); end
        vecs++; if (data_sdram !== 32'h0) begin errs++; $display("FAIL midrst_data: got %h want 0", data_sdram); end
        tick();
        vecs++; if (dv_n !== 0) begin errs++; $display("FAIL midrst_pulse: got %0d want 0", dv_n); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_addr_wrap();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_raw(1'b0);
        test_raw(1'b1);
        test_read_pending();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
